// File: rtl/fp_divsqrt_ctrl.sv
// Issue/stall/writeback controller for the shared iterative FDIV/FSQRT unit.
// Optional stall-cycle counter port is enabled by defining FP_DIVSQRT_PERF_EN.
module fp_divsqrt_ctrl #(
  parameter int ITER_LAT = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic       i_issue_valid,
  input  logic       i_issue_is_iter,
  input  logic [4:0] i_issue_rs1,
  input  logic [4:0] i_issue_rs2,
  input  logic [4:0] i_issue_rs3,
  input  logic [4:0] i_issue_rd,
  input  logic [2:0] i_issue_src_en,
  input  logic       i_issue_wr_en,
  input  logic       i_pipe_wb_valid,
  output logic       o_stall,
  output logic       o_iter_start,
  output logic       o_iter_wb,
  output logic [4:0] o_iter_rd,
  output logic       o_busy
`ifdef FP_DIVSQRT_PERF_EN
  ,
  output logic [31:0] o_stall_cycles
`endif
);

  localparam int CW = (ITER_LAT > 1) ? $clog2(ITER_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          hazard;
  logic          accept;

  // Any register of the ID instruction that collides with the in-flight destination
  assign hazard = (i_issue_src_en[0] & (i_issue_rs1 == o_iter_rd))
                | (i_issue_src_en[1] & (i_issue_rs2 == o_iter_rd))
                | (i_issue_src_en[2] & (i_issue_rs3 == o_iter_rd))
                | (i_issue_wr_en     & (i_issue_rd  == o_iter_rd));

  assign accept = (state == IDLE) & i_issue_valid & i_issue_is_iter & ~i_flush & ~o_stall;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; RUN spans ITER_LAT cycles as the counter drains from ITER_LAT-1
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
        else        state_nxt = IDLE;
      end
      RUN: begin
        if (cnt == {CW{1'b0}}) state_nxt = WB;
        else                   state_nxt = RUN;
      end
      WB: begin
        if (i_pipe_wb_valid) state_nxt = WB;
        else                 state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; WB keeps stalling so nothing is accepted in the grant cycle
  always_comb begin
    o_busy    = 1'b0;
    o_iter_wb = 1'b0;
    case (state)
      IDLE: begin
        o_busy    = 1'b0;
        o_iter_wb = 1'b0;
      end
      RUN: begin
        o_busy    = 1'b1;
        o_iter_wb = 1'b0;
      end
      WB: begin
        o_busy    = 1'b1;
        o_iter_wb = ~i_pipe_wb_valid;
      end
      default: begin
        o_busy    = 1'b0;
        o_iter_wb = 1'b0;
      end
    endcase
    o_stall = i_issue_valid & ~i_flush & o_busy & (i_issue_is_iter | hazard);
  end

  // Latency counter, destination latch and start pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt          <= {CW{1'b0}};
      o_iter_rd    <= 5'd0;
      o_iter_start <= 1'b0;
    end else begin
      o_iter_start <= accept;
      if (accept) begin
        cnt       <= CW'(ITER_LAT - 1);
        o_iter_rd <= i_issue_rd;
      end else if ((state == RUN) && (cnt != {CW{1'b0}})) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt <= cnt;
      end
    end
  end

`ifdef FP_DIVSQRT_PERF_EN
  // Stall-cycle counter, wraps naturally at 2^32
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cycles <= 32'd0;
    end else if (o_stall) begin
      o_stall_cycles <= o_stall_cycles + 32'd1;
    end else begin
      o_stall_cycles <= o_stall_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_fp_divsqrt_ctrl.sv
// Self-checking bench for fp_divsqrt_ctrl (ITER_LAT=4): directed scenarios then random traffic,
// checked every cycle against a cycle-arithmetic reference model.
module tb_fp_divsqrt_ctrl;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0, valid = 1'b0, is_iter = 1'b0, wr_en = 1'b0, pipe_wb = 1'b0;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rs3 = 5'd0, rd = 5'd0;
  logic [2:0] src_en = 3'd0;
  logic       stall, iter_start, iter_wb, busy;
  logic [4:0] iter_rd;
`ifdef FP_DIVSQRT_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] m_perf = 32'd0;
  logic [31:0] perf_base;
`endif

  fp_divsqrt_ctrl #(.ITER_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_issue_valid(valid),
    .i_issue_is_iter(is_iter), .i_issue_rs1(rs1), .i_issue_rs2(rs2), .i_issue_rs3(rs3),
    .i_issue_rd(rd), .i_issue_src_en(src_en), .i_issue_wr_en(wr_en),
    .i_pipe_wb_valid(pipe_wb), .o_stall(stall), .o_iter_start(iter_start),
    .o_iter_wb(iter_wb), .o_iter_rd(iter_rd), .o_busy(busy)
`ifdef FP_DIVSQRT_PERF_EN
    , .o_stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: an op is "active" from the cycle after acceptance until its writeback cycle
  bit         m_active = 1'b0;
  int         m_start = 0;
  logic [4:0] m_rd = 5'd0;

  // Observations from the DUT used by the directed checks
  int last_start_cyc = -1;
  int last_wb_cyc = -1;
  int wb_count = 0;
  int stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; valid = 1'b0; is_iter = 1'b0; wr_en = 1'b0; pipe_wb = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rs3 = 5'd0; rd = 5'd0; src_en = 3'd0;
  endtask

  // Compare at the falling edge, then advance the model on the rising edge
  task automatic cycle();
    bit e_start, e_wb, e_stall, e_acc, haz;
    @(negedge clk);
    if (!rst_n) begin
      m_active = 1'b0;
      m_rd = 5'd0;
`ifdef FP_DIVSQRT_PERF_EN
      m_perf = 32'd0;
`endif
    end
    haz = (src_en[0] && rs1 == m_rd) || (src_en[1] && rs2 == m_rd) ||
          (src_en[2] && rs3 == m_rd) || (wr_en && rd == m_rd);
    e_start = m_active && (cyc == m_start);
    e_wb    = m_active && (cyc >= m_start + LAT) && !pipe_wb;
    e_stall = valid && !flush && m_active && (is_iter || haz);
    e_acc   = rst_n && !m_active && valid && is_iter && !flush;
    chk("busy",  {31'd0, busy},       {31'd0, m_active});
    chk("start", {31'd0, iter_start}, {31'd0, e_start});
    chk("wb",    {31'd0, iter_wb},    {31'd0, e_wb});
    chk("stall", {31'd0, stall},      {31'd0, e_stall});
    chk("rd",    {27'd0, iter_rd},    {27'd0, m_rd});
`ifdef FP_DIVSQRT_PERF_EN
    chk("perf", stall_cycles, m_perf);
`endif
    if (iter_start) last_start_cyc = cyc;
    if (iter_wb) begin last_wb_cyc = cyc; wb_count++; end
    if (stall) stall_cnt++;
    @(posedge clk);
    if (rst_n) begin
`ifdef FP_DIVSQRT_PERF_EN
      if (e_stall) m_perf = m_perf + 32'd1;
`endif
      if (e_wb) m_active = 1'b0;
      if (e_acc) begin m_active = 1'b1; m_start = cyc + 1; m_rd = rd; end
    end
    #1;
    cyc++;
  endtask

  task automatic issue_iter(input logic [4:0] dst);
    idle_inputs();
    valid = 1'b1; is_iter = 1'b1; rd = dst; wr_en = 1'b1;
  endtask

  initial begin
    int t0;
    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // FDIV rd=3, no pipeline contention
    issue_iter(5'd3); t0 = cyc; cycle();
    idle_inputs();
    repeat (7) cycle();
    chk("fdiv_start_cyc", last_start_cyc, t0 + 1);
    chk("fdiv_wb_cyc", last_wb_cyc, t0 + 5);

    // Same op, pipeline owns the write port in cycles 5..7
    issue_iter(5'd3); t0 = cyc; cycle();
    idle_inputs();
    for (int k = 1; k <= 10; k++) begin
      pipe_wb = (k >= 5 && k <= 7);
      cycle();
    end
    pipe_wb = 1'b0;
    chk("pipe_prio_wb_cyc", last_wb_cyc, t0 + 8);

    // RAW hazard FADD at cycle 2, independent FADD at cycle 3
    issue_iter(5'd3); t0 = cyc; cycle();
    idle_inputs(); cycle();
    valid = 1'b1; rs2 = 5'd3; src_en = 3'b011; wr_en = 1'b1; rd = 5'd7;
    stall_cnt = 0; cycle();
    chk("raw_stall", stall_cnt, 1);
    rs1 = 5'd4; rs2 = 5'd5; rd = 5'd6;
    stall_cnt = 0; cycle();
    chk("indep_no_stall", stall_cnt, 0);
    idle_inputs();
    repeat (5) cycle();

    // Second FSQRT issued at cycle 2 waits through WB, accepted at 6
    issue_iter(5'd3); t0 = cyc; cycle();
    idle_inputs(); cycle();
    stall_cnt = 0;
`ifdef FP_DIVSQRT_PERF_EN
    perf_base = stall_cycles;
`endif
    issue_iter(5'd9);
    repeat (5) cycle();
    idle_inputs();
    chk("fsqrt_stall_cnt", stall_cnt, 4);
    repeat (2) cycle();
    chk("fsqrt_start_cyc", last_start_cyc, t0 + 7);
`ifdef FP_DIVSQRT_PERF_EN
    chk("perf_stall_cycles", stall_cycles - perf_base, 32'd4);
`endif
    repeat (6) cycle();

    // Flushed FDIV is never accepted
    last_start_cyc = -1;
    issue_iter(5'd3); flush = 1'b1; cycle();
    idle_inputs(); repeat (3) cycle();
    chk("flush_no_start", last_start_cyc, -1);

    // Reset mid-RUN discards the op
    issue_iter(5'd12); cycle();
    idle_inputs(); repeat (2) cycle();
    rst_n = 1'b0; wb_count = 0; cycle();
    rst_n = 1'b1;
    repeat (10) cycle();
    chk("reset_no_wb", wb_count, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      valid   = ($urandom_range(0, 1) == 1);
      is_iter = ($urandom_range(0, 2) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      pipe_wb = ($urandom_range(0, 2) == 0);
      wr_en   = ($urandom_range(0, 1) == 1);
      src_en  = 3'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rs3 = 5'($urandom_range(0, 7)); rd  = 5'($urandom_range(0, 7));
      rst_n   = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_divsqrt_ctrl.md
FP_DIVSQRT_CTRL -- requirements
Module: fp_divsqrt_ctrl

Interface
- REQ-001 SHALL have parameter ITER_LAT, default 12, meaning the fixed cycle count of the shared iterative FDIV/FSQRT unit; legal range 2..64.
- REQ-002 SHALL have port i_clk, input, 1, clock; reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
- REQ-004 SHALL have port i_flush, input, 1, kills the ID-stage instruction this cycle.
- REQ-005 SHALL have port i_issue_valid, input, 1, ID stage holds a valid FP instruction.
- REQ-006 SHALL have port i_issue_is_iter, input, 1, ID instruction is FDIV.S or FSQRT.S.
- REQ-007 SHALL have ports i_issue_rs1, i_issue_rs2, i_issue_rs3, i_issue_rd, each input, 5, FP register indices of the ID instruction.
- REQ-008 SHALL have port i_issue_src_en, input, 3, per-source read enables for bits [0]=rs1, [1]=rs2, [2]=rs3.
- REQ-009 SHALL have port i_issue_wr_en, input, 1, ID instruction writes the FP register file.
- REQ-010 SHALL have port i_pipe_wb_valid, input, 1, the pipelined FP result owns the FP write port this cycle.
- REQ-011 SHALL have port o_stall, output, 1, hold the IF/ID stages.
- REQ-012 SHALL have port o_iter_start, output, 1, one-cycle start pulse to the iterative unit.
- REQ-013 SHALL have ports o_iter_wb, output, 1, iterative result granted the write port; and o_iter_rd, output, 5, its destination.
- REQ-014 SHALL have port o_busy, output, 1, an iterative operation is in flight.

Function
- REQ-015 SHALL implement states IDLE, RUN and WB, with o_busy = (state != IDLE).
- REQ-016 SHALL accept an op in IDLE when i_issue_valid & i_issue_is_iter & !i_flush & !o_stall, then latch i_issue_rd into o_iter_rd and go to RUN.
- REQ-017 SHALL assert o_iter_start exactly in the first RUN cycle (accept cycle T, pulse at T+1).
- REQ-018 SHALL stay in RUN for exactly ITER_LAT cycles (T+1 .. T+ITER_LAT) using a $clog2(ITER_LAT)-bit down-counter, then enter WB.
- REQ-019 SHALL, in WB, assert o_iter_wb combinationally when !i_pipe_wb_valid and return to IDLE next cycle; if i_pipe_wb_valid is set, remain in WB with o_iter_wb=0 (pipeline has priority).
- REQ-020 SHALL drive o_stall = i_issue_valid & !i_flush & o_busy & (i_issue_is_iter | (src_en[0] & rs1==o_iter_rd) | (src_en[1] & rs2==o_iter_rd) | (src_en[2] & rs3==o_iter_rd) | (i_issue_wr_en & rd==o_iter_rd)); f0 is a real register, so no index is excluded.
- REQ-021 SHALL keep o_stall asserted in the WB grant cycle, with no new accept in that cycle.
- REQ-022 SHALL NOT abort an in-flight op on i_flush; i_flush only blocks acceptance and stall in its cycle.

Reset
- REQ-023 SHALL asynchronously force state=IDLE, counter=0, o_iter_rd=0, o_iter_start=0, o_iter_wb=0, o_stall=0 and o_busy=0 on reset.
- REQ-024 SHALL discard an in-flight op if reset is asserted mid-RUN or mid-WB, producing no o_iter_wb after release.

Configuration
- REQ-025 SHALL, with FP_DIVSQRT_PERF_EN defined, add port o_stall_cycles (output, 32) that counts cycles with o_stall=1, resets to 0, and wraps at 2^32-1 to 0.
- REQ-026 SHALL, without FP_DIVSQRT_PERF_EN, omit that port and counter, with all other behaviour identical.

Verification (ITER_LAT=4)
- REQ-027 SHALL cover: FDIV rd=3 accepted at cycle 0, i_pipe_wb_valid=0 -> o_iter_start at 1, o_busy 1..5, o_iter_wb=1 and o_iter_rd=3 at 5, o_busy=0 at 6.
- REQ-028 SHALL cover: same op with i_pipe_wb_valid=1 for cycles 5..7 -> o_iter_wb=0 at 5..7, =1 at 8.
- REQ-029 SHALL cover: cycle 2, FADD with rs2=3 and src_en=3'b011 -> o_stall=1; with rs1=4, rs2=5 and rd=6 -> o_stall=0.
- REQ-030 SHALL cover: second FSQRT issued at cycle 2 -> o_stall=1 through cycle 5, then accepted at 6 with o_iter_start at 7.
- REQ-031 SHALL cover: FDIV with i_flush=1 at cycle 0 -> no o_iter_start, o_busy stays 0; i_rst_n low at cycle 3 -> all outputs 0 and no o_iter_wb afterward.
- REQ-032 SHALL cover: with FP_DIVSQRT_PERF_EN defined, the REQ-030 scenario -> o_stall_cycles=4.
